instr_fetch_stage: RTL and testbench
====================================

INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 stall_i  input  1  downstream hazard stall; holds the IF/ID register.
REQ-005 flush_i  input  1  taken branch; redirects PC to branch_target_i.
REQ-006 branch_target_i  input  32  redirect address, sampled only when flush_i=1.
REQ-007 imem_req_o  output  1  instruction-memory request.
REQ-008 imem_addr_o  output  32  request address, word aligned.
REQ-009 imem_ack_i  input  1  memory completion; 1 cycle, only while imem_req_o=1.
REQ-010 imem_data_i  input  32  instruction word, valid in the ack cycle.
REQ-011 instr_o  output  32  IF/ID instruction word to the control decoder; 32'h0 is a nop.
REQ-012 pc_plus4_o  output  32  IF/ID PC+4 of instr_o.
REQ-013 valid_o  output  1  instr_o holds a real fetched instruction.
REQ-014 fetch_cnt_o, bubble_cnt_o  output  32 each  performance counters (REQ-031).

Function
REQ-015 States: IDLE, REQ, HOLD, DRAIN; PC register pc; request-address register req_addr drives imem_addr_o.
REQ-016 IDLE: imem_req_o=0; next cycle -> REQ with req_addr=pc.
REQ-017 REQ: imem_req_o=1. Protocol: at most one outstanding request; imem_req_o and imem_addr_o stay stable from assertion through the ack cycle.
REQ-018 REQ, ack, no flush, no stall: IF/ID <= {imem_data_i, req_addr+4}, valid_o<=1, pc<=pc+4, next request at pc+4 the following cycle (one instruction per cycle with zero-wait memory).
REQ-019 REQ, ack, stall, no flush: word captured in hold buffer, pc<=pc+4, IF/ID unchanged, -> HOLD.
REQ-020 REQ, no ack, no stall, no flush: IF/ID <= bubble (instr_o=0, valid_o=0, pc_plus4_o unchanged).
REQ-021 REQ, no ack, stall: IF/ID unchanged.
REQ-022 HOLD: imem_req_o=0; when stall_i=0, IF/ID <= hold buffer with valid_o=1, -> REQ with req_addr=pc.
REQ-023 flush_i has priority over stall_i and ack in every state: IF/ID <= bubble, pc<=branch_target_i.
REQ-024 Flush in REQ with ack in the same cycle: returned word discarded; stay in REQ; next request at branch_target_i.
REQ-025 Flush in REQ without ack: -> DRAIN; request kept at old req_addr until ack; the acked word is discarded; then -> REQ at pc.
REQ-026 Flush in HOLD discards the hold buffer; -> REQ at branch_target_i. A second flush in DRAIN overwrites pc with the newest target.
REQ-027 PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. Bits [1:0] of branch_target_i are forced to 0.

Reset
REQ-028 While rst_i=1 at a clock edge: state=IDLE, pc=RESET_PC, req_addr=RESET_PC, imem_req_o=0, instr_o=0, pc_plus4_o=0, valid_o=0, hold buffer cleared, counters=0.
REQ-029 Reset during an outstanding request drops imem_req_o in the next cycle; the abandoned request is not tracked and a late ack is ignored.
REQ-030 First instruction: reset released at cycle 0 -> IDLE at cycle 0, request at RESET_PC at cycle 1, with same-cycle ack valid_o=1 at cycle 2.

Configuration
REQ-031 Macro FETCH_PERF_CNT_EN defined: fetch_cnt_o increments on each IF/ID load with valid_o=1; bubble_cnt_o increments on each IF/ID bubble load; both wrap at 2^32. Undefined: both ports tied to 0 and no counter flops.

Verification
REQ-032 Zero-wait memory returning addr as data, RESET_PC=0 -> instr_o = 0,4,8,C on consecutive cycles from cycle 2; valid_o=1 throughout.
REQ-033 Ack 2 cycles after request -> exactly 2 bubble cycles (instr_o=0, valid_o=0) between valid instructions; bubble_cnt_o=2 per instruction when FETCH_PERF_CNT_EN is defined.
REQ-034 stall_i=1 for 3 cycles while the fetch of 0x10 acks -> instr_o holds the prior word for 3 cycles, then word at 0x10, then word at 0x14; nothing lost or duplicated.
REQ-035 flush_i=1 with target 0x40 while a request to 0x20 is outstanding and acks 2 cycles later -> the 0x20 word never appears; next valid_o=1 carries the word at 0x40 with pc_plus4_o=0x44.
REQ-036 flush_i=1 and stall_i=1 in the same cycle as an ack -> IF/ID bubble; the next request is at the target address.
REQ-037 rst_i asserted mid-wait, then a late ack -> imem_req_o=0 the next cycle, all outputs at reset values, late ack ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory request/acknowledge bundle between the fetch stage (master) and memory (slave).
interface instr_fetch_stage_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;

    modport master (output imem_req_o, output imem_addr_o, input imem_ack_i, input imem_data_i);
    modport slave  (input imem_req_o, input imem_addr_o, output imem_ack_i, output imem_data_i);
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requests feeding the IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       stall_i,
    input  logic                       flush_i,
    input  logic [31:0]                branch_target_i,
    instr_fetch_stage_if.master        imem,
    output logic [31:0]                instr_o,
    output logic [31:0]                pc_plus4_o,
    output logic                       valid_o,
    output logic [31:0]                fetch_cnt_o,
    output logic [31:0]                bubble_cnt_o
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DRAIN} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   req_addr_q, req_addr_d;
    logic              req_q, req_d;
    logic [XLEN-1:0]   hold_q, hold_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   pc4_q, pc4_d;
    logic              valid_q, valid_d;
    logic              ifid_load;
    logic              mem_ack;
    logic [XLEN-1:0]   target;

    // Acks are only meaningful while a request is outstanding; late acks after reset are dropped.
    assign mem_ack = imem.imem_ack_i && ((state_q == S_REQ) || (state_q == S_DRAIN));
    assign target  = branch_target_i & ~XLEN'(3);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ: begin
                if (flush_i)                 state_d = mem_ack ? S_REQ : S_DRAIN;
                else if (mem_ack && stall_i) state_d = S_HOLD;
            end
            S_HOLD:  if (flush_i || !stall_i) state_d = S_REQ;
            S_DRAIN: if (mem_ack) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        hold_d     = hold_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        ifid_load  = 1'b0;
        if (flush_i) begin
            ifid_load = 1'b1;
            instr_d   = '0;
            valid_d   = 1'b0;
            pc_d      = target;
            hold_d    = '0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (mem_ack && !stall_i) begin
                        ifid_load = 1'b1;
                        instr_d   = imem.imem_data_i;
                        pc4_d     = req_addr_q + XLEN'(4);
                        valid_d   = 1'b1;
                        pc_d      = pc_q + XLEN'(4);
                    end else if (mem_ack) begin
                        hold_d = imem.imem_data_i;
                        pc_d   = pc_q + XLEN'(4);
                    end else if (!stall_i) begin
                        ifid_load = 1'b1;
                        instr_d   = '0;
                        valid_d   = 1'b0;
                    end
                end
                // pc already advanced past the held word, so it is that word's PC+4.
                S_HOLD: begin
                    if (!stall_i) begin
                        ifid_load = 1'b1;
                        instr_d   = hold_q;
                        pc4_d     = pc_q;
                        valid_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // A new request is issued on entering REQ or after each completed request in REQ.
        if ((state_d == S_REQ) && ((state_q != S_REQ) || mem_ack)) req_addr_d = pc_d;
        req_d = (state_d == S_REQ) || (state_d == S_DRAIN);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            req_q      <= 1'b0;
            hold_q     <= '0;
            instr_q    <= '0;
            pc4_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            req_q      <= req_d;
            hold_q     <= hold_d;
            if (ifid_load) begin
                instr_q <= instr_d;
                pc4_q   <= pc4_d;
                valid_q <= valid_d;
            end
        end
    end

    assign imem.imem_req_o  = req_q;
    assign imem.imem_addr_o = req_addr_q;
    assign instr_o          = instr_q;
    assign pc_plus4_o       = pc4_q;
    assign valid_o          = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [XLEN-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q + XLEN'(ifid_load && valid_d);
        bubble_cnt_d = bubble_cnt_q + XLEN'(ifid_load && !valid_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    assign fetch_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed self-checking bench for instr_fetch_stage with a latency-programmable memory model.
module tb_instr_fetch_stage;
    logic        clk;
    logic        rst_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] branch_target_i;
    logic [31:0] instr_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;
    logic [31:0] fetch_cnt_o;
    logic [31:0] bubble_cnt_o;

    int checks = 0;
    int errors = 0;

    // Memory model: acks after lat waiting cycles, returns the address as data.
    int   lat = 0;
    int   wait_cnt = 0;
    logic mem_en = 1'b1;
    logic late_ack = 1'b0;

    instr_fetch_stage_if imem ();

    instr_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_target_i (branch_target_i),
        .imem            (imem),
        .instr_o         (instr_o),
        .pc_plus4_o      (pc_plus4_o),
        .valid_o         (valid_o),
        .fetch_cnt_o     (fetch_cnt_o),
        .bubble_cnt_o    (bubble_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        imem.imem_ack_i  = (mem_en && imem.imem_req_o && (wait_cnt == lat)) || late_ack;
        imem.imem_data_i = imem.imem_addr_o;
    end

    always @(posedge clk) begin
        if (imem.imem_req_o && !imem.imem_ack_i) wait_cnt <= wait_cnt + 1;
        else                                     wait_cnt <= 0;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge of cycle 0 (first cycle with reset released).
    task automatic do_reset(input int latency);
        lat = latency; mem_en = 1'b1; late_ack = 1'b0;
        stall_i = 1'b0; flush_i = 1'b0; branch_target_i = 32'h0;
        rst_i = 1'b1;
        repeat (2) cyc();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        lat = 0; mem_en = 1'b1; late_ack = 1'b0;
        stall_i = 1'b0; flush_i = 1'b0; branch_target_i = 32'h0;
        rst_i = 1'b1;
        repeat (2) cyc();
        checks++; if (imem.imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %0h exp 0", imem.imem_req_o); end
        checks++; if (imem.imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %08h exp 00000000", imem.imem_addr_o); end
        checks++; if (instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr got %08h exp 00000000", instr_o); end
        checks++; if (pc_plus4_o !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %08h exp 00000000", pc_plus4_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", valid_o); end
        checks++; if (fetch_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_fetch_cnt got %0d exp 0", fetch_cnt_o); end
        checks++; if (bubble_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_bubble_cnt got %0d exp 0", bubble_cnt_o); end
        rst_i = 1'b0;
        checks++; if (imem.imem_req_o !== 1'b0) begin errors++; $display("FAIL idle_cycle0_req got %0h exp 0", imem.imem_req_o); end
    endtask

    task automatic test_zero_wait();
        do_reset(0);
        cyc();
        checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h0) begin errors++; $display("FAIL zw_first_req got req=%0h addr=%08h exp req=1 addr=00000000", imem.imem_req_o, imem.imem_addr_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL zw_cycle1_valid got %0h exp 0", valid_o); end
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_i;
            exp_i = 32'(4 * k);
            cyc();
            checks++; if (instr_o !== exp_i || valid_o !== 1'b1 || pc_plus4_o !== exp_i + 32'd4) begin errors++; $display("FAIL zw_stream[%0d] got instr=%08h valid=%0h pc4=%08h exp instr=%08h valid=1 pc4=%08h", k, instr_o, valid_o, pc_plus4_o, exp_i, exp_i + 32'd4); end
        end
    endtask

    task automatic test_wait_states();
        do_reset(2);
        cyc();
        for (int i = 0; i < 9; i++) begin
            logic [31:0] exp_i;
            logic [31:0] exp_f;
            logic [31:0] exp_b;
            cyc();
            if (i % 3 == 2) begin
                exp_i = 32'(4 * (i / 3));
                checks++; if (instr_o !== exp_i || valid_o !== 1'b1 || pc_plus4_o !== exp_i + 32'd4) begin errors++; $display("FAIL ws_valid[%0d] got instr=%08h valid=%0h pc4=%08h exp instr=%08h valid=1 pc4=%08h", i, instr_o, valid_o, pc_plus4_o, exp_i, exp_i + 32'd4); end
`ifdef FETCH_PERF_CNT_EN
                exp_f = 32'(i / 3 + 1);
                exp_b = 32'(2 * (i / 3 + 1));
`else
                exp_f = 32'h0;
                exp_b = 32'h0;
`endif
                checks++; if (fetch_cnt_o !== exp_f || bubble_cnt_o !== exp_b) begin errors++; $display("FAIL ws_counters[%0d] got fetch=%0d bubble=%0d exp fetch=%0d bubble=%0d", i, fetch_cnt_o, bubble_cnt_o, exp_f, exp_b); end
            end else begin
                exp_i = (i < 2) ? 32'h0 : 32'(4 * (i / 3));
                checks++; if (instr_o !== 32'h0 || valid_o !== 1'b0 || pc_plus4_o !== exp_i) begin errors++; $display("FAIL ws_bubble[%0d] got instr=%08h valid=%0h pc4=%08h exp instr=00000000 valid=0 pc4=%08h", i, instr_o, valid_o, pc_plus4_o, exp_i); end
            end
        end
    endtask

    task automatic test_stall();
        do_reset(0);
        repeat (5) cyc();
        checks++; if (instr_o !== 32'hC || imem.imem_addr_o !== 32'h10) begin errors++; $display("FAIL st_pre got instr=%08h addr=%08h exp instr=0000000c addr=00000010", instr_o, imem.imem_addr_o); end
        stall_i = 1'b1;
        for (int s = 0; s < 3; s++) begin
            cyc();
            checks++; if (instr_o !== 32'hC || valid_o !== 1'b1 || imem.imem_req_o !== 1'b0) begin errors++; $display("FAIL st_hold[%0d] got instr=%08h valid=%0h req=%0h exp instr=0000000c valid=1 req=0", s, instr_o, valid_o, imem.imem_req_o); end
        end
        stall_i = 1'b0;
        cyc();
        checks++; if (instr_o !== 32'h10 || pc_plus4_o !== 32'h14 || valid_o !== 1'b1) begin errors++; $display("FAIL st_release got instr=%08h pc4=%08h valid=%0h exp instr=00000010 pc4=00000014 valid=1", instr_o, pc_plus4_o, valid_o); end
        checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h14) begin errors++; $display("FAIL st_next_req got req=%0h addr=%08h exp req=1 addr=00000014", imem.imem_req_o, imem.imem_addr_o); end
        cyc();
        checks++; if (instr_o !== 32'h14 || pc_plus4_o !== 32'h18 || valid_o !== 1'b1) begin errors++; $display("FAIL st_after got instr=%08h pc4=%08h valid=%0h exp instr=00000014 pc4=00000018 valid=1", instr_o, pc_plus4_o, valid_o); end
    endtask

    task automatic test_flush_outstanding();
        do_reset(2);
        repeat (25) cyc();
        checks++; if (instr_o !== 32'h1C || imem.imem_addr_o !== 32'h20 || imem.imem_req_o !== 1'b1) begin errors++; $display("FAIL fo_pre got instr=%08h addr=%08h req=%0h exp instr=0000001c addr=00000020 req=1", instr_o, imem.imem_addr_o, imem.imem_req_o); end
        flush_i = 1'b1; branch_target_i = 32'h40;
        cyc();
        flush_i = 1'b0; branch_target_i = 32'h0;
        for (int c = 0; c < 5; c++) begin
            checks++; if (instr_o !== 32'h0 || valid_o !== 1'b0) begin errors++; $display("FAIL fo_bubble[%0d] got instr=%08h valid=%0h exp instr=00000000 valid=0", c, instr_o, valid_o); end
            if (c < 2) begin
                checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h20) begin errors++; $display("FAIL fo_drain_req[%0d] got req=%0h addr=%08h exp req=1 addr=00000020", c, imem.imem_req_o, imem.imem_addr_o); end
            end else if (c == 2) begin
                checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h40) begin errors++; $display("FAIL fo_redirect got req=%0h addr=%08h exp req=1 addr=00000040", imem.imem_req_o, imem.imem_addr_o); end
            end
            cyc();
        end
        checks++; if (instr_o !== 32'h40 || pc_plus4_o !== 32'h44 || valid_o !== 1'b1) begin errors++; $display("FAIL fo_target got instr=%08h pc4=%08h valid=%0h exp instr=00000040 pc4=00000044 valid=1", instr_o, pc_plus4_o, valid_o); end
    endtask

    task automatic test_flush_stall_ack();
        do_reset(0);
        repeat (3) cyc();
        checks++; if (instr_o !== 32'h4 || imem.imem_addr_o !== 32'h8) begin errors++; $display("FAIL fs_pre got instr=%08h addr=%08h exp instr=00000004 addr=00000008", instr_o, imem.imem_addr_o); end
        flush_i = 1'b1; stall_i = 1'b1; branch_target_i = 32'h82;
        cyc();
        flush_i = 1'b0; stall_i = 1'b0; branch_target_i = 32'h0;
        checks++; if (instr_o !== 32'h0 || valid_o !== 1'b0 || pc_plus4_o !== 32'h8) begin errors++; $display("FAIL fs_bubble got instr=%08h valid=%0h pc4=%08h exp instr=00000000 valid=0 pc4=00000008", instr_o, valid_o, pc_plus4_o); end
        checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h80) begin errors++; $display("FAIL fs_req got req=%0h addr=%08h exp req=1 addr=00000080", imem.imem_req_o, imem.imem_addr_o); end
        cyc();
        checks++; if (instr_o !== 32'h80 || pc_plus4_o !== 32'h84 || valid_o !== 1'b1) begin errors++; $display("FAIL fs_target got instr=%08h pc4=%08h valid=%0h exp instr=00000080 pc4=00000084 valid=1", instr_o, pc_plus4_o, valid_o); end
    endtask

    task automatic test_wrap();
        do_reset(0);
        repeat (2) cyc();
        flush_i = 1'b1; branch_target_i = 32'hFFFF_FFFF;
        cyc();
        flush_i = 1'b0; branch_target_i = 32'h0;
        checks++; if (imem.imem_addr_o !== 32'hFFFF_FFFC || valid_o !== 1'b0) begin errors++; $display("FAIL wr_req got addr=%08h valid=%0h exp addr=fffffffc valid=0", imem.imem_addr_o, valid_o); end
        cyc();
        checks++; if (instr_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0 || valid_o !== 1'b1) begin errors++; $display("FAIL wr_top got instr=%08h pc4=%08h valid=%0h exp instr=fffffffc pc4=00000000 valid=1", instr_o, pc_plus4_o, valid_o); end
        checks++; if (imem.imem_addr_o !== 32'h0) begin errors++; $display("FAIL wr_next_addr got %08h exp 00000000", imem.imem_addr_o); end
        cyc();
        checks++; if (instr_o !== 32'h0 || pc_plus4_o !== 32'h4 || valid_o !== 1'b1) begin errors++; $display("FAIL wr_after got instr=%08h pc4=%08h valid=%0h exp instr=00000000 pc4=00000004 valid=1", instr_o, pc_plus4_o, valid_o); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset(0);
        repeat (3) cyc();
        mem_en = 1'b0;
        cyc();
        checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h8 || pc_plus4_o !== 32'h8) begin errors++; $display("FAIL rm_wait got req=%0h addr=%08h pc4=%08h exp req=1 addr=00000008 pc4=00000008", imem.imem_req_o, imem.imem_addr_o, pc_plus4_o); end
        rst_i = 1'b1;
        cyc();
        checks++; if (imem.imem_req_o !== 1'b0 || imem.imem_addr_o !== 32'h0) begin errors++; $display("FAIL rm_req_drop got req=%0h addr=%08h exp req=0 addr=00000000", imem.imem_req_o, imem.imem_addr_o); end
        checks++; if (instr_o !== 32'h0 || pc_plus4_o !== 32'h0 || valid_o !== 1'b0) begin errors++; $display("FAIL rm_outputs got instr=%08h pc4=%08h valid=%0h exp instr=00000000 pc4=00000000 valid=0", instr_o, pc_plus4_o, valid_o); end
        rst_i = 1'b0; late_ack = 1'b1;
        cyc();
        late_ack = 1'b0; mem_en = 1'b1;
        checks++; if (valid_o !== 1'b0 || pc_plus4_o !== 32'h0) begin errors++; $display("FAIL rm_late_ack got valid=%0h pc4=%08h exp valid=0 pc4=00000000", valid_o, pc_plus4_o); end
        checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h0) begin errors++; $display("FAIL rm_restart_req got req=%0h addr=%08h exp req=1 addr=00000000", imem.imem_req_o, imem.imem_addr_o); end
        cyc();
        checks++; if (instr_o !== 32'h0 || pc_plus4_o !== 32'h4 || valid_o !== 1'b1) begin errors++; $display("FAIL rm_restart got instr=%08h pc4=%08h valid=%0h exp instr=00000000 pc4=00000004 valid=1", instr_o, pc_plus4_o, valid_o); end
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; branch_target_i = 32'h0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_flush_outstanding();
        test_flush_stall_ack();
        test_wrap();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
